// File: rtl/spi_word_reader.sv
// spi_word_reader: SPI master fetching one WORD_BITS-wide word per request.
// A transaction sends one address-load sck pulse with ss high, then
// LEAD_BITS + WORD_BITS pulses with ss low, sampling miso on falling edges,
// and finishes with a re-arm gap of ss high / sck low.
// Optional build macro SPI_RD_AUTOINC_EN: holding start high at the end of
// the gap chains straight into the next word at addr_out + 1.
module spi_word_reader #(
    parameter int CLK_DIV   = 2,
    parameter int WORD_BITS = 32,
    parameter int LEAD_BITS = 1,
    parameter int ADDR_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    addr_in,
    output logic                 busy,
    output logic [WORD_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic [ADDR_W-1:0]    addr_out,
    output logic                 sck,
    output logic                 ss,
    output logic                 mosi,
    input  logic                 miso
);

    localparam int TOTAL_BITS = LEAD_BITS + WORD_BITS;
    localparam int BW = $clog2(TOTAL_BITS + 1);
    localparam int HW = $clog2(CLK_DIV + 1);
    localparam int GW = $clog2(2 * CLK_DIV + 1);

    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(TOTAL_BITS);
    localparam logic [BW-1:0] LEAD_CNT  = BW'(LEAD_BITS);
    localparam logic [GW-1:0] GAP_LAST  = GW'(2 * CLK_DIV);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    state_t               state, state_next;
    logic [HW-1:0]        half_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [GW-1:0]        gap_cnt;
    logic [WORD_BITS-1:0] shreg;

    logic half_wrap;
    logic pulse_end;
    logic gap_end;
    logic chain;

    assign half_wrap = (half_cnt == HALF_LAST);
    // A pulse is finished once its low half-period has elapsed.
    assign pulse_end = half_wrap && !sck;
    assign gap_end   = (gap_cnt == GAP_LAST);
    assign mosi      = 1'b0;

`ifdef SPI_RD_AUTOINC_EN
    assign chain = start;
`else
    assign chain = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode: phases advance on completed sck pulses / gap expiry.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (pulse_end) state_next = SHIFT;
            SHIFT:   if (pulse_end && (bit_cnt == BIT_LAST)) state_next = GAP;
            GAP:     if (gap_end) state_next = chain ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered sck/ss timing, miso capture and result/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_cnt   <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            shreg      <= '0;
            sck        <= 1'b0;
            ss         <= 1'b1;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= '0;
            addr_out   <= '0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    half_cnt <= '0;
                    if (start) begin
                        // Entering LOAD is itself the address-load rising edge.
                        addr_out <= addr_in;
                        busy     <= 1'b1;
                        sck      <= 1'b1;
                    end
                end
                LOAD: begin
                    half_cnt <= half_wrap ? '0 : half_cnt + 1'b1;
                    if (half_wrap) begin
                        if (sck) begin
                            sck <= 1'b0;
                        end else begin
                            // First shift pulse rises together with ss falling.
                            sck     <= 1'b1;
                            ss      <= 1'b0;
                            bit_cnt <= '0;
                        end
                    end
                end
                SHIFT: begin
                    half_cnt <= half_wrap ? '0 : half_cnt + 1'b1;
                    if (half_wrap) begin
                        if (sck) begin
                            // Falling edge: miso has been stable for a half-period.
                            sck     <= 1'b0;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt >= LEAD_CNT)
                                shreg <= {shreg[WORD_BITS-2:0], miso};
                        end else if (bit_cnt == BIT_LAST) begin
                            ss         <= 1'b1;
                            data_valid <= 1'b1;
                            data_out   <= shreg;
                            gap_cnt    <= '0;
                        end else begin
                            sck <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_end) begin
                        gap_cnt <= '0;
                        if (chain) begin
                            addr_out <= addr_out + 1'b1;
                            sck      <= 1'b1;
                            half_cnt <= '0;
                        end else begin
                            busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    sck <= 1'b0;
                    ss  <= 1'b1;
                end
            endcase
        end
    end

endmodule
